// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller between VGA, CPU and aux masters.
// VGA has priority with a starvation limit; CPU and aux alternate round-robin.
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH = 24,
  parameter int VGA_MAX    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic                  vga_ack,
  input  logic                  cpu_req,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [15:0]           cpu_wdata,
  input  logic [1:0]            cpu_bytesel,
  output logic                  cpu_ack,
  input  logic                  aux_req,
  input  logic                  aux_wr,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [15:0]           aux_wdata,
  input  logic [1:0]            aux_bytesel,
  output logic                  aux_ack,
  output logic [15:0]           q,
  output logic                  sdr_req,
  output logic                  sdr_wr,
  output logic [ADDR_WIDTH-1:0] sdr_addr,
  output logic [15:0]           sdr_wdata,
  output logic [1:0]            sdr_bytesel,
  input  logic                  sdr_ack,
  input  logic [15:0]           sdr_q,
  output logic [1:0]            owner
);
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  state_t                state_q, state_d;
  logic [3:0]            vga_run_q, vga_run_d;
  logic                  rr_last_q, rr_last_d;
  logic                  sdr_req_q, sdr_req_d;
  logic                  sdr_wr_q, sdr_wr_d;
  logic [ADDR_WIDTH-1:0] sdr_addr_q, sdr_addr_d;
  logic [15:0]           sdr_wdata_q, sdr_wdata_d;
  logic [1:0]            sdr_bytesel_q, sdr_bytesel_d;
  logic [15:0]           q_q, q_d;
  logic [1:0]            owner_q, owner_d;
  logic                  vga_ack_q, vga_ack_d, cpu_ack_q, cpu_ack_d, aux_ack_q, aux_ack_d;
  logic                  other, vga_win, cpu_win;
  assign other   = cpu_req | aux_req;
  assign vga_win = vga_req && !(vga_run_q == 4'(VGA_MAX) && other);
  // rr_last=1 means aux was served last, so the CPU takes the tie
  assign cpu_win = !vga_win && cpu_req && (!aux_req || rr_last_q);
  always_comb begin
    state_d       = state_q;
    vga_run_d     = vga_run_q;
    rr_last_d     = rr_last_q;
    sdr_req_d     = sdr_req_q;
    sdr_wr_d      = sdr_wr_q;
    sdr_addr_d    = sdr_addr_q;
    sdr_wdata_d   = sdr_wdata_q;
    sdr_bytesel_d = sdr_bytesel_q;
    q_d           = q_q;
    owner_d       = owner_q;
    vga_ack_d     = 1'b0;
    cpu_ack_d     = 1'b0;
    aux_ack_d     = 1'b0;
    if (state_q == IDLE) begin
      if (vga_req | other) begin
        state_d       = BUSY;
        sdr_req_d     = 1'b1;
        owner_d       = vga_win ? 2'd1 : cpu_win ? 2'd2 : 2'd3;
        sdr_wr_d      = vga_win ? 1'b0 : cpu_win ? cpu_wr : aux_wr;
        sdr_addr_d    = vga_win ? vga_addr : cpu_win ? cpu_addr : aux_addr;
        sdr_wdata_d   = vga_win ? sdr_wdata_q : cpu_win ? cpu_wdata : aux_wdata;
        sdr_bytesel_d = vga_win ? 2'b11 : cpu_win ? cpu_bytesel : aux_bytesel;
        vga_run_d     = (vga_win && other) ? ((vga_run_q == 4'(VGA_MAX)) ? vga_run_q : vga_run_q + 4'd1) : 4'd0;
        rr_last_d     = vga_win ? rr_last_q : !cpu_win;
      end
    end else if (state_q == BUSY) begin
      if (sdr_ack) begin
        state_d   = ACK;
        sdr_req_d = 1'b0;
        q_d       = sdr_q;
        vga_ack_d = owner_q == 2'd1;
        cpu_ack_d = owner_q == 2'd2;
        aux_ack_d = owner_q == 2'd3;
      end
    end else begin
      state_d = IDLE;
      owner_d = 2'd0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      vga_run_q     <= 4'd0;
      rr_last_q     <= 1'b1;
      sdr_req_q     <= 1'b0;
      sdr_wr_q      <= 1'b0;
      sdr_addr_q    <= '0;
      sdr_wdata_q   <= 16'd0;
      sdr_bytesel_q <= 2'd0;
      q_q           <= 16'd0;
      owner_q       <= 2'd0;
      vga_ack_q     <= 1'b0;
      cpu_ack_q     <= 1'b0;
      aux_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      vga_run_q     <= vga_run_d;
      rr_last_q     <= rr_last_d;
      sdr_req_q     <= sdr_req_d;
      sdr_wr_q      <= sdr_wr_d;
      sdr_addr_q    <= sdr_addr_d;
      sdr_wdata_q   <= sdr_wdata_d;
      sdr_bytesel_q <= sdr_bytesel_d;
      q_q           <= q_d;
      owner_q       <= owner_d;
      vga_ack_q     <= vga_ack_d;
      cpu_ack_q     <= cpu_ack_d;
      aux_ack_q     <= aux_ack_d;
    end
  end
  assign vga_ack     = vga_ack_q;
  assign cpu_ack     = cpu_ack_q;
  assign aux_ack     = aux_ack_q;
  assign q           = q_q;
  assign sdr_req     = sdr_req_q;
  assign sdr_wr      = sdr_wr_q;
  assign sdr_addr    = sdr_addr_q;
  assign sdr_wdata   = sdr_wdata_q;
  assign sdr_bytesel = sdr_bytesel_q;
  assign owner       = owner_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed bench for sdram_port_arbiter with a
// fixed-latency SDRAM controller stand-in and an ack log.
module tb_sdram_port_arbiter;
  localparam int AW = 24;
  logic clk = 1'b0, reset_n = 1'b0;
  logic vga_req = 0, cpu_req = 0, cpu_wr = 0, aux_req = 0, aux_wr = 0;
  logic [AW-1:0] vga_addr = '0, cpu_addr = '0, aux_addr = '0, sdr_addr;
  logic [15:0] cpu_wdata = 0, aux_wdata = 0, q, sdr_wdata, sdr_q_r = 0;
  logic [1:0] cpu_bytesel = 0, aux_bytesel = 0, sdr_bytesel, owner;
  logic vga_ack, cpu_ack, aux_ack, sdr_req, sdr_wr;
  logic sdr_ack_r = 0, stray_ack = 0;
  int tests = 0, fails = 0, lat = 4, cnt = 0, n;
  bit resp_en = 1;
  logic [15:0] rd_val = 0;
  int glog[$];
  int pat[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 3};

  sdram_port_arbiter #(.ADDR_WIDTH(AW), .VGA_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_bytesel(cpu_bytesel), .cpu_ack(cpu_ack),
    .aux_req(aux_req), .aux_wr(aux_wr), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_bytesel(aux_bytesel), .aux_ack(aux_ack),
    .q(q), .sdr_req(sdr_req), .sdr_wr(sdr_wr), .sdr_addr(sdr_addr), .sdr_wdata(sdr_wdata),
    .sdr_bytesel(sdr_bytesel), .sdr_ack(sdr_ack_r | stray_ack),
    .sdr_q(stray_ack ? 16'hdead : sdr_q_r), .owner(owner)
  );

  always #5 clk = ~clk;

  // Controller stand-in: acks a held sdr_req after lat cycles, for one cycle
  initial forever begin
    @(posedge clk);
    #1;
    if (!reset_n) begin
      cnt = 0;
      sdr_ack_r = 0;
    end else if (resp_en) begin
      if (sdr_ack_r) begin
        sdr_ack_r = 0;
        cnt = 0;
      end else if (sdr_req) begin
        cnt++;
        if (cnt >= lat) begin
          sdr_ack_r = 1;
          sdr_q_r = rd_val;
        end
      end else cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (vga_ack | cpu_ack | aux_ack) begin
      chk("ack_onehot", $countones({vga_ack, cpu_ack, aux_ack}), 1);
      glog.push_back(vga_ack ? 1 : cpu_ack ? 2 : 3);
    end
  endtask

  task automatic wait_ack(input string tag);
    int k = 0;
    do begin
      step();
      k++;
    end while (!(vga_ack | cpu_ack | aux_ack) && k < 100);
    chk(tag, k < 100, 1);
  endtask

  task automatic run_grants(input int num);
    int k = 0;
    while (glog.size() < num && k < 500) begin
      step();
      k++;
    end
    chk("grant_count", glog.size() >= num, 1);
  endtask

  task automatic do_reset();
    reset_n = 0;
    repeat (2) step();
    reset_n = 1;
    step();
  endtask

  initial begin
    repeat (2) step();
    chk("rst_outputs", {sdr_req, owner, sdr_wr, sdr_bytesel, vga_ack, cpu_ack, aux_ack}, 0);
    chk("rst_q", q, 0);
    chk("rst_addr", sdr_addr, 0);
    reset_n = 1;
    step();

    // single CPU write
    lat = 4; rd_val = 16'h5a5a; glog.delete();
    cpu_addr = 24'h000100; cpu_wdata = 16'hbeef; cpu_bytesel = 2'b10; cpu_wr = 1; cpu_req = 1;
    step();
    chk("wr_sdr_req", sdr_req, 1);
    chk("wr_owner", owner, 2);
    chk("wr_sdr_wr", sdr_wr, 1);
    chk("wr_bytesel", sdr_bytesel, 2'b10);
    chk("wr_addr", sdr_addr, 24'h000100);
    chk("wr_wdata", sdr_wdata, 16'hbeef);
    n = 1;
    while (!cpu_ack && n < 50) begin
      step();
      n++;
    end
    chk("wr_latency", n, 5);
    chk("wr_q", q, 16'h5a5a);
    cpu_req = 0;
    step();
    chk("wr_ack_pulse", cpu_ack, 0);
    chk("wr_owner_clr", owner, 0);
    repeat (3) step();
    chk("wr_no_regrant", glog.size(), 1);

    // CPU/aux round robin from reset
    do_reset();
    lat = 1; glog.delete(); cpu_wr = 0;
    aux_addr = 24'h000200; aux_wdata = 16'h0a0a; aux_bytesel = 2'b01; aux_wr = 1;
    cpu_req = 1; aux_req = 1;
    run_grants(4);
    cpu_req = 0; aux_req = 0;
    for (int i = 0; i < 4; i++) chk($sformatf("rr_%0d", i), glog.size() > i ? glog[i] : 0, (i % 2) ? 3 : 2);
    repeat (3) step();

    // VGA starvation limit
    do_reset();
    glog.delete();
    vga_req = 1; cpu_req = 1; aux_req = 1;
    run_grants(10);
    vga_req = 0; cpu_req = 0; aux_req = 0;
    for (int i = 0; i < 10; i++) chk($sformatf("vpat_%0d", i), glog.size() > i ? glog[i] : 0, pat[i]);
    repeat (3) step();

    // VGA read
    lat = 2; rd_val = 16'h1234; vga_addr = 24'h0abcde; glog.delete();
    vga_req = 1;
    step();
    chk("vga_owner", owner, 1);
    chk("vga_addr", sdr_addr, 24'h0abcde);
    n = 0;
    while (!vga_ack && n < 50) begin
      chk("vga_wr", sdr_wr, 0);
      chk("vga_bytesel", sdr_bytesel, 2'b11);
      step();
      n++;
    end
    chk("vga_acked", vga_ack, 1);
    chk("vga_q", q, 16'h1234);
    vga_req = 0;
    step();
    chk("vga_ack_pulse", vga_ack, 0);
    repeat (2) step();
    chk("vga_once", glog.size(), 1);

    // async reset during BUSY
    lat = 10; cpu_req = 1;
    step();
    chk("busy_owner", owner, 2);
    repeat (2) step();
    #2 reset_n = 0;
    #1;
    chk("async_rst_ctl", {sdr_req, owner, sdr_wr, sdr_bytesel, vga_ack, cpu_ack, aux_ack}, 0);
    chk("async_rst_q", q, 0);
    chk("async_rst_addr", sdr_addr, 0);
    chk("async_rst_wdata", sdr_wdata, 0);
    repeat (2) step();
    lat = 3; rd_val = 16'h7777; glog.delete();
    reset_n = 1;
    wait_ack("post_rst_ack");
    chk("post_rst_who", glog.size() > 0 ? glog[0] : 0, 2);
    chk("post_rst_q", q, 16'h7777);
    cpu_req = 0;
    repeat (3) step();
    chk("post_rst_idle", owner, 0);

    // stray sdr_ack in IDLE
    resp_en = 0; stray_ack = 1;
    step();
    stray_ack = 0;
    repeat (2) step();
    resp_en = 1;
    chk("stray_q", q, 16'h7777);
    chk("stray_owner", owner, 0);
    chk("stray_req", sdr_req, 0);
    chk("stray_noack", glog.size(), 1);

    // CPU drops req one cycle after grant
    glog.delete(); lat = 3; cpu_req = 1;
    step();
    chk("drop_owner", owner, 2);
    step();
    cpu_req = 0;
    repeat (12) step();
    chk("drop_acks", glog.size(), 1);
    chk("drop_who", glog.size() > 0 ? glog[0] : 0, 2);
    chk("drop_owner_end", owner, 0);
    chk("drop_req_end", sdr_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
